// File: rtl/resp_checker_pkg.sv
// Shared types, constants and the bus-to-signature fold for the lockstep
// response checker.
//   Build option: RESP_CHECKER_SIG_EN enables the MISR signature logic.
package resp_checker_pkg;

    localparam int unsigned OUT_W  = 330;
    localparam int unsigned CNT_W  = 32;
    localparam int unsigned SIG_W  = 32;
    localparam int unsigned NSLICE = (OUT_W + SIG_W - 1) / SIG_W;
    localparam int unsigned PAD_W  = NSLICE * SIG_W;

    localparam logic [SIG_W-1:0] POLY = 32'h04C11DB7;
    localparam logic [SIG_W-1:0] SEED = 32'hFFFFFFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // XOR of all SIG_W-bit slices; the top slice is zero-padded.
    function automatic logic [SIG_W-1:0] fold(input logic [OUT_W-1:0] data);
        logic [PAD_W-1:0] padded;
        logic [SIG_W-1:0] acc;
        padded = PAD_W'(data);
        acc    = '0;
        for (int i = 0; i < int'(NSLICE); i++) begin
            acc = acc ^ padded[i*SIG_W +: SIG_W];
        end
        return acc;
    endfunction

endpackage

// File: rtl/resp_misr.sv
// Multiple-input signature register compacting one DUT output stream.
//   clk, rst_n : clock, asynchronous active-low reset (sig cleared to 0)
//   load       : reload signature with SEED (takes priority over en)
//   en         : fold data into the signature this cycle
//   data       : DUT output bus
//   sig        : registered signature
module resp_misr
    import resp_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [OUT_W-1:0] data,
    output logic [SIG_W-1:0] sig
);

    logic [SIG_W-1:0] r_sig;
    logic [SIG_W-1:0] w_fb;

    // Galois-style feedback from the bit shifted out of the top
    assign w_fb = r_sig[SIG_W-1] ? POLY : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sig <= '0;
        end else if (load) begin
            r_sig <= SEED;
        end else if (en) begin
            r_sig <= {r_sig[SIG_W-2:0], 1'b0} ^ w_fb ^ fold(data);
        end
    end

    assign sig = r_sig;

endmodule

// File: rtl/resp_checker.sv
// Lockstep response checker: compares reference and candidate DUT output
// buses for a programmed number of valid samples, records the first
// divergence, counts mismatches and (optionally) builds MISR signatures.
//   Build option: RESP_CHECKER_SIG_EN adds two MISRs; otherwise sig_a/sig_b are 0.
//   Inputs : clk, rst_n, start, cycles, valid, out_a, out_b
//   Outputs: busy, done, mismatch, first_mis, mis_count, sig_a, sig_b (registered)
module resp_checker
    import resp_checker_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [CNT_W-1:0] cycles,
    input  logic             valid,
    input  logic [OUT_W-1:0] out_a,
    input  logic [OUT_W-1:0] out_b,
    output logic             busy,
    output logic             done,
    output logic             mismatch,
    output logic [CNT_W-1:0] first_mis,
    output logic [CNT_W-1:0] mis_count,
    output logic [SIG_W-1:0] sig_a,
    output logic [SIG_W-1:0] sig_b
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             w_accept;
    logic             w_sample;
    logic             w_last;
    logic             w_diff;

    logic [CNT_W-1:0] r_cycles;
    logic [CNT_W-1:0] r_sample_idx;
    logic             r_busy;
    logic             r_done;
    logic             r_mismatch;
    logic [CNT_W-1:0] r_first_mis;
    logic [CNT_W-1:0] r_mis_count;
    logic [SIG_W-1:0] w_sig_a;
    logic [SIG_W-1:0] w_sig_b;

    assign w_diff = (out_a != out_b);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next state plus per-cycle strobes for the datapath
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_sample    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = (cycles == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (valid) begin
                    w_sample = 1'b1;
                    // r_cycles is never 0 in RUN, so the subtraction cannot wrap
                    if (r_sample_idx == r_cycles - CNT_W'(1)) begin
                        w_last      = 1'b1;
                        w_state_nxt = DONE;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Run bookkeeping: counters, first-mismatch capture and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cycles     <= '0;
            r_sample_idx <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_mismatch   <= 1'b0;
            r_first_mis  <= '0;
            r_mis_count  <= '0;
        end else begin
            r_busy <= (w_state_nxt == RUN);
            // Pulse on entry to DONE, including a zero-length run
            r_done <= w_last | (w_accept & (cycles == '0));
            if (w_accept) begin
                r_cycles     <= cycles;
                r_sample_idx <= '0;
                r_mismatch   <= 1'b0;
                r_first_mis  <= '0;
                r_mis_count  <= '0;
            end else if (w_sample) begin
                r_sample_idx <= r_sample_idx + CNT_W'(1);
                if (w_diff) begin
                    if (r_mis_count != '1) begin
                        r_mis_count <= r_mis_count + CNT_W'(1);
                    end
                    if (!r_mismatch) begin
                        r_mismatch  <= 1'b1;
                        r_first_mis <= r_sample_idx;
                    end
                end
            end
        end
    end

`ifdef RESP_CHECKER_SIG_EN
    resp_misr u_misr_a (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .en    (w_sample),
        .data  (out_a),
        .sig   (w_sig_a)
    );

    resp_misr u_misr_b (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (w_accept),
        .en    (w_sample),
        .data  (out_b),
        .sig   (w_sig_b)
    );
`else
    assign w_sig_a = '0;
    assign w_sig_b = '0;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign mismatch  = r_mismatch;
    assign first_mis = r_first_mis;
    assign mis_count = r_mis_count;
    assign sig_a     = w_sig_a;
    assign sig_b     = w_sig_b;

endmodule

// File: tb/tb_resp_checker.sv
// Self-checking bench for resp_checker: reset, identical streams, single and
// multiple divergences (table-driven, with valid gaps), zero-length run,
// ignored start during RUN, mid-run reset and a hand-computed signature.
module tb_resp_checker;
    import resp_checker_pkg::*;

    localparam int unsigned NROWS = 15;
    localparam logic [31:0] M_POLY = 32'h04C11DB7;
    localparam logic [31:0] M_SEED = 32'hFFFFFFFF;
`ifdef RESP_CHECKER_SIG_EN
    localparam logic [31:0] SIG_MASK = 32'hFFFFFFFF;
`else
    localparam logic [31:0] SIG_MASK = 32'h00000000;
`endif

    typedef struct {
        logic             valid;
        logic             diff;
        logic             live;
        logic             e_busy;
        logic             e_done;
        logic             e_mm;
        logic [CNT_W-1:0] e_cnt;
        logic [CNT_W-1:0] e_fm;
    } vec_t;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [CNT_W-1:0] cycles;
    logic             valid;
    logic [OUT_W-1:0] out_a;
    logic [OUT_W-1:0] out_b;
    logic             busy;
    logic             done;
    logic             mismatch;
    logic [CNT_W-1:0] first_mis;
    logic [CNT_W-1:0] mis_count;
    logic [SIG_W-1:0] sig_a;
    logic [SIG_W-1:0] sig_b;

    int          n_checks;
    int          n_fail;
    logic [31:0] m_sig_a;
    logic [31:0] m_sig_b;
    logic [31:0] lcg_state;
    vec_t        tbl [NROWS];

    resp_checker dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cycles    (cycles),
        .valid     (valid),
        .out_a     (out_a),
        .out_b     (out_b),
        .busy      (busy),
        .done      (done),
        .mismatch  (mismatch),
        .first_mis (first_mis),
        .mis_count (mis_count),
        .sig_a     (sig_a),
        .sig_b     (sig_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bitwise fold: bus bit j lands on signature bit j mod 32
    function automatic logic [31:0] m_fold(input logic [OUT_W-1:0] d);
        logic [31:0] f;
        f = '0;
        for (int j = 0; j < int'(OUT_W); j++) f[j % 32] = f[j % 32] ^ d[j];
        return f;
    endfunction

    function automatic logic [31:0] m_step(input logic [31:0] s, input logic [OUT_W-1:0] d);
        logic [31:0] n;
        n = s << 1;
        if (s[31]) n = n ^ M_POLY;
        return n ^ m_fold(d);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic check_status(input string tag, input logic eb, input logic ed, input logic emm,
                                input logic [CNT_W-1:0] ecnt, input logic [CNT_W-1:0] efm);
        check({tag, "_busy"},      64'(busy),      64'(eb));
        check({tag, "_done"},      64'(done),      64'(ed));
        check({tag, "_mismatch"},  64'(mismatch),  64'(emm));
        check({tag, "_mis_count"}, 64'(mis_count), 64'(ecnt));
        check({tag, "_first_mis"}, 64'(first_mis), 64'(efm));
    endtask

    task automatic check_sigs(input string tag);
        check({tag, "_sig_a"}, 64'(sig_a), 64'(m_sig_a & SIG_MASK));
        check({tag, "_sig_b"}, 64'(sig_b), 64'(m_sig_b & SIG_MASK));
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic gen_bus(output logic [OUT_W-1:0] b);
        logic [PAD_W-1:0] tmp;
        tmp = '0;
        for (int w = 0; w < int'(NSLICE); w++) begin
            lcg_state = lcg_state * 32'd1664525 + 32'd1013904223;
            tmp[w*32 +: 32] = lcg_state;
        end
        b = OUT_W'(tmp);
    endtask

    task automatic apply(input logic v, input logic [OUT_W-1:0] a, input logic [OUT_W-1:0] b,
                         input logic live);
        out_a = a;
        out_b = b;
        valid = v;
        if (v && live) begin
            m_sig_a = m_step(m_sig_a, a);
            m_sig_b = m_step(m_sig_b, b);
        end
        tick();
    endtask

    task automatic start_run(input logic [CNT_W-1:0] n);
        start   = 1'b1;
        cycles  = n;
        valid   = 1'b0;
        m_sig_a = M_SEED;
        m_sig_b = M_SEED;
        tick();
        start = 1'b0;
    endtask

    task automatic set_row(input int i, input int v, input int d, input int l, input int b,
                           input int dn, input int mm, input int cnt, input int fm);
        tbl[i].valid  = 1'(v);
        tbl[i].diff   = 1'(d);
        tbl[i].live   = 1'(l);
        tbl[i].e_busy = 1'(b);
        tbl[i].e_done = 1'(dn);
        tbl[i].e_mm   = 1'(mm);
        tbl[i].e_cnt  = CNT_W'(cnt);
        tbl[i].e_fm   = CNT_W'(fm);
    endtask

    initial begin
        logic [OUT_W-1:0] a;
        logic [OUT_W-1:0] b;
        logic [OUT_W-1:0] zero;
        n_checks  = 0;
        n_fail    = 0;
        lcg_state = 32'h1234_5678;
        zero      = '0;

        // cycles=10, mismatches on samples 2, 5, 9; valid=0 rows carry differing data
        //        v  d  live busy done mm cnt fm
        set_row( 0, 1, 0, 1, 1, 0, 0, 0, 0);
        set_row( 1, 1, 0, 1, 1, 0, 0, 0, 0);
        set_row( 2, 1, 1, 1, 1, 0, 1, 1, 2);
        set_row( 3, 0, 1, 0, 1, 0, 1, 1, 2);
        set_row( 4, 1, 0, 1, 1, 0, 1, 1, 2);
        set_row( 5, 1, 0, 1, 1, 0, 1, 1, 2);
        set_row( 6, 0, 1, 0, 1, 0, 1, 1, 2);
        set_row( 7, 0, 1, 0, 1, 0, 1, 1, 2);
        set_row( 8, 1, 1, 1, 1, 0, 1, 2, 2);
        set_row( 9, 1, 0, 1, 1, 0, 1, 2, 2);
        set_row(10, 1, 0, 1, 1, 0, 1, 2, 2);
        set_row(11, 0, 1, 0, 1, 0, 1, 2, 2);
        set_row(12, 1, 0, 1, 1, 0, 1, 2, 2);
        set_row(13, 1, 1, 1, 0, 1, 1, 3, 2);
        set_row(14, 1, 1, 0, 0, 0, 1, 3, 2);

        // Reset
        rst_n  = 1'b0;
        start  = 1'b0;
        cycles = '0;
        valid  = 1'b0;
        out_a  = '0;
        out_b  = '0;
        m_sig_a = '0;
        m_sig_b = '0;
        tick();
        check_status("reset", 0, 0, 0, 0, 0);
        check_sigs("reset");
        rst_n = 1'b1;
        tick();

        // Single all-zero sample: one MISR step from SEED
        start_run(1);
        check("ss_busy", 64'(busy), 64'(1));
        apply(1'b1, zero, zero, 1'b1);
        check_status("ss_end", 0, 1, 0, 0, 0);
        check("ss_sig_a_const", 64'(sig_a), 64'(32'hFB3EE249 & SIG_MASK));
        check("ss_sig_b_const", 64'(sig_b), 64'(32'hFB3EE249 & SIG_MASK));
        check_sigs("ss");

        // Identical streams, 100 samples
        start_run(100);
        for (int i = 0; i < 100; i++) begin
            gen_bus(a);
            apply(1'b1, a, a, 1'b1);
            if (i == 98) check_status("id_98", 1, 0, 0, 0, 0);
        end
        check_status("id_end", 0, 1, 0, 0, 0);
        check_sigs("id");
        check("id_sig_eq", 64'(sig_a == sig_b), 64'(1));
        valid = 1'b0;
        tick();
        check("id_done_pulse", 64'(done), 64'(0));
        check_sigs("id_hold");

        // Single divergence: bit 329 at sample 37
        start_run(100);
        for (int i = 0; i < 100; i++) begin
            gen_bus(a);
            b = a;
            if (i == 37) b[329] = ~b[329];
            apply(1'b1, a, b, 1'b1);
        end
        check_status("div", 0, 1, 1, 1, 37);
        check_sigs("div");
`ifdef RESP_CHECKER_SIG_EN
        check("div_sig_differ", 64'(sig_a != sig_b), 64'(1));
`endif

        // Table-driven multi-mismatch run with valid gaps
        start_run(10);
        for (int r = 0; r < int'(NROWS); r++) begin
            gen_bus(a);
            b = a;
            if (tbl[r].diff) b[(r * 23) % int'(OUT_W)] = ~b[(r * 23) % int'(OUT_W)];
            apply(tbl[r].valid, a, b, tbl[r].live);
            check_status($sformatf("tbl%0d", r), tbl[r].e_busy, tbl[r].e_done, tbl[r].e_mm,
                         tbl[r].e_cnt, tbl[r].e_fm);
        end
        check_sigs("tbl");

        // Zero-length run from DONE
        start_run(0);
        check_status("zero", 0, 1, 0, 0, 0);
        check("zero_sig_a", 64'(sig_a), 64'(M_SEED & SIG_MASK));
        check_sigs("zero");
        tick();
        check("zero_pulse", 64'(done), 64'(0));

        // Start during RUN is ignored
        start_run(5);
        gen_bus(a); b = a; b[0] = ~b[0];
        apply(1'b1, a, b, 1'b1);
        gen_bus(a);
        apply(1'b1, a, a, 1'b1);
        start  = 1'b1;
        cycles = '0;
        gen_bus(a); b = ~a;
        apply(1'b0, a, b, 1'b0);
        start = 1'b0;
        check_status("ign", 1, 0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            gen_bus(a);
            b = a;
            if (i == 2) b[200] = ~b[200];
            apply(1'b1, a, b, 1'b1);
        end
        check_status("ign_end", 0, 1, 1, 2, 0);
        check_sigs("ign");

        // Mid-run reset at sample 50
        start_run(100);
        for (int i = 0; i < 50; i++) begin
            gen_bus(a);
            b = a;
            if (i == 10) b[5] = ~b[5];
            apply(1'b1, a, b, 1'b1);
        end
        rst_n   = 1'b0;
        m_sig_a = '0;
        m_sig_b = '0;
        #2;
        check_status("rst_now", 0, 0, 0, 0, 0);
        check_sigs("rst_now");
        tick();
        tick();
        check("rst_no_done", 64'(done), 64'(0));
        rst_n = 1'b1;
        valid = 1'b0;
        tick();
        start_run(3);
        for (int i = 0; i < 3; i++) begin
            gen_bus(a);
            apply(1'b1, a, a, 1'b1);
        end
        check_status("post_rst", 0, 1, 0, 0, 0);
        check_sigs("post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/resp_checker.md
# resp_checker

Lockstep response checker at the output end of the fuzz harness; the stimulus side drives a 261-bit random vector into two DUT builds each cycle. This block consumes both 330-bit DUT output buses and compares them for a programmed number of samples. It records the first divergence, counts mismatches, and compacts each stream into a MISR signature, so runs can be triaged in hardware or emulation without per-cycle text dumps.

## Interface
- OUT_W, 330, width of each DUT output bus
- CNT_W, 32, width of sample counters
- SIG_W, 32, signature width
- clk  in  1  sole clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  pulse; begin a run (accepted in IDLE or DONE only)
- cycles  in  CNT_W  samples to check, latched on accepted start
- valid  in  1  out_a/out_b carry a sample this cycle
- out_a  in  OUT_W  reference DUT output
- out_b  in  OUT_W  candidate DUT output
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run
- mismatch  out  1  sticky; any mismatch seen this run
- first_mis  out  CNT_W  0-based sample index of first mismatch
- mis_count  out  CNT_W  number of mismatching samples, saturating
- sig_a  out  SIG_W  MISR signature of out_a
- sig_b  out  SIG_W  MISR signature of out_b

## Operation
- States: IDLE, RUN, DONE.
  - IDLE: start → RUN, or → DONE if cycles==0.
  - RUN: on the valid sample with index cycles-1 → DONE.
  - DONE: start → as from IDLE; otherwise hold.
- Accepted start: latch cycles; clear sample counter, mismatch, first_mis, mis_count; load signatures with SEED.
- start while in RUN is ignored.
- In RUN with valid=1:
  - compare out_a != out_b over full OUT_W.
  - On mismatch: mis_count+1, saturating at all-ones. If mismatch was 0, set it and capture first_mis = current sample index.
  - Update both signatures; increment the sample counter.
- valid=0 in RUN: no state change.
- Samples in IDLE or DONE are ignored.
- Signature fold: XOR all SIG_W-bit slices of the bus, top slice zero-padded. For 330/32 that is 11 slices, slice 10 being bits [329:320].
- Signature update: sig ← {sig[SIG_W-2:0],0} ^ (sig[SIG_W-1] ? POLY : 0) ^ fold, with POLY=32'h04C11DB7 and SEED=32'hFFFFFFFF.
- Results hold in DONE until the next accepted start.

## Timing
- Reset values: state IDLE; busy=0, done=0, mismatch=0, first_mis=0, mis_count=0, sig_a=0, sig_b=0.
- All outputs are registered.
- busy=1 on the cycle after an accepted start, and stays 1 through the cycle containing the final valid sample.
- done pulses one cycle after the final sample is registered; first_mis, mis_count and signatures are final on that same cycle.
- cycles==0: done pulses one cycle after start; signatures equal SEED; counts are 0.
- Asserting rst_n low mid-run forces reset values immediately, with no done pulse.
- Final sample mismatching: it is counted before done.

## Configuration
- RESP_CHECKER_SIG_EN defined: both MISRs present; sig_a and sig_b behave as above.
- RESP_CHECKER_SIG_EN undefined: no MISR logic; sig_a and sig_b tied to 0; comparison and counters unchanged.

## Structure
- Package resp_checker_pkg holds:
  - state enum (IDLE/RUN/DONE)
  - POLY and SEED constants
  - fold function parameterised on OUT_W/SIG_W
- Sub-module resp_misr (inputs clk, rst_n, load, en, data; output sig): instantiated twice, only under RESP_CHECKER_SIG_EN.

## Test plan
- Identical streams: cycles=100, out_a=out_b from LCG for 100 samples → done one cycle after sample 99; mismatch=0; mis_count=0; sig_a==sig_b.
- Single divergence: bit 329 flipped on out_b at sample 37 of 100 → mismatch=1, first_mis=37, mis_count=1, sig_a!=sig_b.
- Multiple divergences, with valid=0 gaps: cycles=10, mismatches at samples 2, 5 and 9 → first_mis=2, mis_count=3; samples during gaps are not counted.
- Zero-length run: start with cycles=0 → done one cycle later, signatures=32'hFFFFFFFF, and start during a later RUN is ignored.
- Mid-run reset: rst_n low at sample 50 of 100 → all outputs return to reset values at once; no done pulse; a new start runs cleanly.
- Single-sample signature check: cycles=1, both buses all-zero → sig = 32'hFFFFFFFE ^ 32'h04C11DB7 = 32'hFB3EE249. With the macro undefined, sig_a=sig_b=0.
